// File: rtl/seg7_capture_pkg.sv
// Shared constants for the multiplexed 7-segment display bus: segment bit
// positions, hex glyph table, blank glyph and the capture FSM state encoding.
package seg7_capture_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high a..g glyphs (bit0 = a) for hex digits 0..F, shared with driver7seg.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [1:0] anode_index(input logic [3:0] an);
    case (an)
      4'b0010: anode_index = 2'd1;
      4'b0100: anode_index = 2'd2;
      4'b1000: anode_index = 2'd3;
      default: anode_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph decoder: maps an active-high a..g pattern to its hex
// value, flagging whether it is a legal hex glyph or the all-off blank glyph.
module seg7_pattern_decode
  import seg7_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic       blank,
  output logic [3:0] value
);

  always_comb begin
    valid = 1'b0;
    value = 4'h0;
    blank = (pattern == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (pattern == HEX_SEG[i]) begin
        valid = 1'b1;
        value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Receive side of the scanned 4-digit 7-segment bus: rebuilds digits, blank/dp/error
// flags and frame pulses. Optional idle watchdog enabled by SEG7_CAPTURE_TIMEOUT_EN.
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter bit ANODE_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW   = 1'b1
`ifdef SEG7_CAPTURE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anodos,
  input  logic [7:0]  segmentos,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  dp,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        multi_err,
  output logic        stalled
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

  logic [3:0] an_s1, an_s2, an_n, an_prev, seen, seen_set;
  logic [7:0] seg_s1, seg_s2, seg_n;
  logic [CNT_W-1:0] settle_cnt;
  state_t state;
  logic an_changed, settle_done, sample_fire;
  logic dec_valid, dec_blank;
  logic [3:0] dec_value;
  logic [1:0] idx;

  // Synchronizer flops reset to the idle (all-off) bus level so no phantom dwell appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_s1  <= {4{ANODE_ACT_LOW}};
      an_s2  <= {4{ANODE_ACT_LOW}};
      seg_s1 <= {8{SEG_ACT_LOW}};
      seg_s2 <= {8{SEG_ACT_LOW}};
    end else begin
      an_s1  <= anodos;
      an_s2  <= an_s1;
      seg_s1 <= segmentos;
      seg_s2 <= seg_s1;
    end
  end

  always_comb begin
    an_n        = ANODE_ACT_LOW ? ~an_s2 : an_s2;
    seg_n       = SEG_ACT_LOW ? ~seg_s2 : seg_s2;
    an_changed  = (an_n != an_prev);
    settle_done = (state == ST_SETTLE) && !an_changed && (settle_cnt == SETTLE_MAX);
    sample_fire = settle_done && $onehot(an_n);
    idx         = anode_index(an_n);
    seen_set    = seen | an_n;
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_n[SEG_G:SEG_A]),
    .valid   (dec_valid),
    .blank   (dec_blank),
    .value   (dec_value)
  );

  // Capture FSM: one sample per anode dwell, taken once the vector has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_WAIT;
      settle_cnt  <= '0;
      an_prev     <= 4'h0;
      digits      <= 16'h0000;
      blank       <= 4'hF;
      dp          <= 4'h0;
      digit_err   <= 4'h0;
      frame_valid <= 1'b0;
      seen        <= 4'h0;
      multi_err   <= 1'b0;
    end else begin
      an_prev     <= an_n;
      frame_valid <= 1'b0;
      case (state)
        ST_SETTLE: begin
          if (an_changed) begin
            settle_cnt <= CNT_W'(1);
          end else if (settle_done) begin
            state <= ST_HOLD;
            if (sample_fire) begin
              dp[idx] <= seg_n[SEG_DP];
              if (dec_valid) begin
                digits[{idx, 2'b00} +: 4] <= dec_value;
                digit_err[idx]            <= 1'b0;
                blank[idx]                <= 1'b0;
              end else if (dec_blank) begin
                digit_err[idx] <= 1'b0;
                blank[idx]     <= 1'b1;
              end else begin
                digit_err[idx] <= 1'b1;
                blank[idx]     <= 1'b0;
              end
              if (seen_set == 4'hF) begin
                frame_valid <= 1'b1;
                seen        <= 4'h0;
              end else begin
                seen <= seen_set;
              end
            end else if (an_n != 4'h0) begin
              multi_err <= 1'b1;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_WAIT, ST_HOLD: begin
          if (an_changed) begin
            state      <= ST_SETTLE;
            settle_cnt <= CNT_W'(1);
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

`ifdef SEG7_CAPTURE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] idle_cnt;

  // Idle watchdog: saturates at the limit and is rearmed by every one-hot sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      stalled  <= 1'b0;
    end else if (sample_fire) begin
      idle_cnt <= '0;
      stalled  <= 1'b0;
    end else if (idle_cnt != TO_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
      stalled  <= ((idle_cnt + 1'b1) == TO_MAX);
    end
  end
`else
  assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scans plus random dwells compared
// against a dwell-level model of the capture rules (active-low bus, default params).
module tb_seg7_capture;

  localparam int SETTLE_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  anodos;
  logic [7:0]  segmentos;
  logic [15:0] digits;
  logic [3:0]  blank, dp, digit_err;
  logic        frame_valid, multi_err, stalled;

  int checks = 0;
  int errors = 0;
  int frame_count = 0;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic [15:0] m_digits;
  logic [3:0]  m_blank, m_dp, m_err, m_seen, m_prev_an;
  logic        m_multi;
  int          m_frames = 0;

`ifdef SEG7_CAPTURE_TIMEOUT_EN
  seg7_capture #(.TIMEOUT_CYCLES(50)) dut (
`else
  seg7_capture dut (
`endif
    .clk         (clk),
    .rst         (rst),
    .anodos      (anodos),
    .segmentos   (segmentos),
    .digits      (digits),
    .blank       (blank),
    .dp          (dp),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .multi_err   (multi_err),
    .stalled     (stalled)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid) frame_count++;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    compare({tag, ".digits"}, 32'(digits), 32'(m_digits));
    compare({tag, ".blank"}, 32'(blank), 32'(m_blank));
    compare({tag, ".dp"}, 32'(dp), 32'(m_dp));
    compare({tag, ".digit_err"}, 32'(digit_err), 32'(m_err));
    compare({tag, ".multi_err"}, 32'(multi_err), 32'(m_multi));
    compare({tag, ".frames"}, 32'(frame_count), 32'(m_frames));
`ifndef SEG7_CAPTURE_TIMEOUT_EN
    compare({tag, ".stalled"}, 32'(stalled), 32'd0);
`endif
  endtask

  task automatic model_reset();
    m_digits  = 16'h0000;
    m_blank   = 4'hF;
    m_dp      = 4'h0;
    m_err     = 4'h0;
    m_seen    = 4'h0;
    m_prev_an = 4'h0;
    m_multi   = 1'b0;
  endtask

  task automatic model_sample(input logic [3:0] an, input logic [6:0] seg, input logic dpv);
    int idx = 0;
    int found = -1;
    for (int i = 0; i < 4; i++) if (an[i]) idx = i;
    for (int i = 0; i < 16; i++) if (hex_tab[i] == seg) found = i;
    if (found >= 0) begin
      m_digits[idx*4 +: 4] = 4'(found);
      m_err[idx]   = 1'b0;
      m_blank[idx] = 1'b0;
    end else if (seg == 7'h00) begin
      m_err[idx]   = 1'b0;
      m_blank[idx] = 1'b1;
    end else begin
      m_err[idx]   = 1'b1;
      m_blank[idx] = 1'b0;
    end
    m_dp[idx]   = dpv;
    m_seen[idx] = 1'b1;
    if (m_seen == 4'hF) begin
      m_frames++;
      m_seen = 4'h0;
    end
  endtask

  // Hold one anode/segment pattern on the pins for len clocks; a dwell on a new
  // vector lasting at least SETTLE_CYCLES+1 clocks yields exactly one sample.
  task automatic apply_stimulus(input string tag, input logic [3:0] an, input logic [6:0] seg,
                                input logic dpv, input int len);
    anodos    = ~an;
    segmentos = ~{dpv, seg};
    if (an != m_prev_an && len >= SETTLE_CYCLES + 1) begin
      if ($countones(an) == 1) model_sample(an, seg, dpv);
      else if (an != 4'h0) m_multi = 1'b1;
    end
    m_prev_an = an;
    for (int i = 1; i <= len; i++) begin
      @(posedge clk);
      #1;
      if (i == 8) check_output(tag);
    end
  endtask

  task automatic do_reset();
    anodos    = 4'hF;
    segmentos = 8'hFF;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] an;
    logic [6:0] seg;
    int r;

    rst       = 1'b1;
    anodos    = 4'hF;
    segmentos = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("reset");

    for (int i = 0; i < 4; i++)
      apply_stimulus("scan", 4'(1 << i), hex_tab[i + 1], 1'b0, 10);
    compare("scan.digits_4321", 32'(digits), 32'h4321);

    apply_stimulus("short_d2", 4'b0100, hex_tab[9], 1'b1, 3);
    apply_stimulus("after_short", 4'h0, 7'h00, 1'b0, 10);
    apply_stimulus("long_d2", 4'b0100, hex_tab[9], 1'b1, 10);

    apply_stimulus("edge4_d3", 4'b1000, hex_tab[12], 1'b0, 4);
    apply_stimulus("after_edge4", 4'h0, 7'h00, 1'b0, 10);
    apply_stimulus("edge5_d3", 4'b1000, hex_tab[13], 1'b1, 5);
    apply_stimulus("after_edge5", 4'h0, 7'h00, 1'b0, 10);

    apply_stimulus("blank_d1", 4'b0010, 7'h00, 1'b0, 10);
    apply_stimulus("gap_d1", 4'h0, 7'h00, 1'b0, 6);
    apply_stimulus("bad_d1", 4'b0010, 7'h55, 1'b1, 10);

    for (int n = 0; n < 40; n++) begin
      do begin
        r  = $urandom_range(0, 99);
        an = (r < 80) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      end while (an == m_prev_an);
      r = $urandom_range(0, 99);
      if (r < 70) seg = hex_tab[$urandom_range(0, 15)];
      else if (r < 80) seg = 7'h00;
      else seg = 7'($urandom);
      apply_stimulus("random", an, seg, 1'($urandom), $urandom_range(2, 12));
    end
    apply_stimulus("random_tail", 4'h0, 7'h00, 1'b0, 10);

    apply_stimulus("multi", 4'b0011, hex_tab[8], 1'b0, 10);
    apply_stimulus("multi_hold", 4'b0001, hex_tab[5], 1'b0, 10);

    for (int i = 0; i < 3; i++)
      apply_stimulus("pre_rst", 4'(1 << i), hex_tab[i + 6], 1'b0, 10);
    apply_stimulus("mid_settle", 4'b1000, hex_tab[15], 1'b0, 4);
    do_reset();
    check_output("mid_rst");
    for (int i = 0; i < 4; i++)
      apply_stimulus("post_rst", 4'(1 << i), hex_tab[10 + i], 1'b0, 10);

`ifdef SEG7_CAPTURE_TIMEOUT_EN
    do_reset();
    apply_stimulus("idle60", 4'h0, 7'h00, 1'b0, 60);
    compare("timeout.stalled_set", 32'(stalled), 32'd1);
    apply_stimulus("wake", 4'b0001, hex_tab[3], 1'b0, 10);
    compare("timeout.stalled_clear", 32'(stalled), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
